// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fifo_arb_pkg: shared types and helpers for the FIFO write arbiter          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int STATS_WIDTH = 16;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_picker: combinational round-robin selector, first set bit from rr_ptr  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  // Scan from the farthest offset down so the nearest hit from rr_ptr wins.
  always_comb begin : p_pick
    int j;
    j   = 0;
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[j]) begin
        any = 1'b1;
        idx = ID_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fifo_wr_arbiter: round-robin packet arbiter onto one FIFO write port.     |
// | Optional per-requester beat counters: define FIFO_ARB_STATS_EN.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_d,
  input  logic                          fifo_full,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_WIDTH-1:0] stats_beats
`endif
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              xfer;
  logic [DATA_WIDTH-1:0] req_beat [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_beat[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign busy     = (state_q == ARB_BURST);
  assign grant_id = grant_q;
  assign xfer     = busy & req_valid[grant_q] & ~fifo_full;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    fifo_we    = 1'b0;
    fifo_d     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // Straight-through path: the granted beat reaches the FIFO this cycle.
        req_ready[grant_q] = ~fifo_full;
        fifo_we            = xfer;
        if (xfer) begin
          fifo_d     = req_beat[grant_q];
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (req_last[grant_q] || (beat_cnt_q == LAST_CNT)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [STATS_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (req_valid[i] && req_ready[i] && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign stats_beats[i*STATS_WIDTH +: STATS_WIDTH] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_fifo_wr_arbiter: randomized self-checking bench with a packet-level    |
// | reference model. Revision: 1.0                                            |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 8;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ready;
  logic              fifo_we;
  logic [DW-1:0]     fifo_d;
  logic              fifo_full = 1'b0;
  logic [IDW-1:0]    grant_id;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0]   stats_beats;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_we   (fifo_we),
    .fifo_d    (fifo_d),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stats_beats (stats_beats)
`endif
  );

  always #5 clk = ~clk;

  // Pending beats per requester: {last, data}
  logic [DW:0] q [N][$];
  int exp_id [N][$];
  int glog [$];
  int dlog [$];

  bit m_busy;
  int m_grant, m_ptr, m_cnt;
  int m_stats [N];
  int hold [N];
  int full_cycles;
  bit rand_gaps, rand_full;
  bit prev_busy;
  int stall_cycles;
  int n_checks, n_errors;

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0; prev_busy = 0;
    full_cycles = 0;
    for (int i = 0; i < N; i++) begin
      m_stats[i] = 0; hold[i] = 0;
      q[i].delete(); exp_id[i].delete();
    end
    glog.delete(); dlog.delete();
  endtask

  task automatic push_pkt(input int id, input int len);
    int d;
    logic lst;
    for (int b = 0; b < len; b++) begin
      d   = int'($urandom_range(255));
      lst = (b == len - 1);
      q[id].push_back({lst, DW'(d)});
      exp_id[id].push_back(d);
    end
  endtask

  task automatic drive_inputs();
    logic v;
    for (int i = 0; i < N; i++) begin
      v = (q[i].size() != 0) && (hold[i] == 0) && !(rand_gaps && $urandom_range(3) == 0);
      req_valid[i] = v;
      req_data[i*DW +: DW] = v ? q[i][0][DW-1:0] : DW'($urandom);
      req_last[i] = v ? q[i][0][DW] : 1'($urandom);
    end
    fifo_full = (full_cycles > 0) ? 1'b1 : (rand_full ? ($urandom_range(4) == 0) : 1'b0);
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the model.
  task automatic step();
    int g;
    bit found, lst;
    logic [N-1:0] exp_ready;
    logic exp_we;
    logic [DW-1:0] exp_d;
    drive_inputs();
    #1;
    g = m_grant;
    exp_ready = (m_busy && !fifo_full) ? (N'(1) << g) : '0;
    exp_we = m_busy && req_valid[g] && !fifo_full;
    exp_d = '0;
    if (exp_we) exp_d = q[g][0][DW-1:0];

    n_checks++;
    if (busy !== m_busy) begin
      n_errors++; $display("FAIL busy @%0t: got %0b want %0b", $time, busy, m_busy);
    end
    n_checks++;
    if (req_ready !== exp_ready) begin
      n_errors++; $display("FAIL req_ready @%0t: got %b want %b", $time, req_ready, exp_ready);
    end
    n_checks++;
    if (fifo_we !== exp_we) begin
      n_errors++; $display("FAIL fifo_we @%0t: got %0b want %0b", $time, fifo_we, exp_we);
    end
    n_checks++;
    if (fifo_d !== exp_d) begin
      n_errors++; $display("FAIL fifo_d @%0t: got %h want %h", $time, fifo_d, exp_d);
    end
    n_checks++;
    if (grant_id !== IDW'(m_grant)) begin
      n_errors++; $display("FAIL grant_id @%0t: got %0d want %0d", $time, grant_id, m_grant);
    end

    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    if (fifo_we) dlog.push_back(int'(grant_id) * 256 + int'(fifo_d));
    if (busy && !fifo_we) stall_cycles++;
    prev_busy = busy;

    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found = 1; m_grant = (m_ptr + k) % N; m_busy = 1; m_cnt = 0;
        end
      end
    end else if (exp_we) begin
      lst = q[g][0][DW];
      void'(q[g].pop_front());
      m_cnt++;
      if (m_stats[g] < 65535) m_stats[g]++;
      if (lst || m_cnt == MB) begin
        m_busy = 0; m_ptr = (g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) if (hold[i] > 0) hold[i]--;
    if (full_cycles > 0) full_cycles--;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_drained(input int max_cycles, output int cycles);
    cycles = 0;
    while ((pending() || m_busy) && cycles < max_cycles) begin
      step(); cycles++;
    end
    n_checks++;
    if (pending() || m_busy) begin
      n_errors++; $display("FAIL drain_timeout: still busy after %0d cycles (limit %0d)", cycles, max_cycles);
    end
  endtask

  task automatic wait_writes(input int count);
    int c;
    c = 0;
    while (dlog.size() < count && c < 100) begin step(); c++; end
    n_checks++;
    if (dlog.size() < count) begin
      n_errors++; $display("FAIL wait_writes: got %0d writes want %0d", dlog.size(), count);
    end
  endtask

  task automatic check_grants(input string name, input int exp_g[$]);
    n_checks++;
    if (glog.size() != exp_g.size()) begin
      n_errors++; $display("FAIL %s grant_count: got %0d want %0d", name, glog.size(), exp_g.size());
    end else begin
      foreach (exp_g[k]) begin
        n_checks++;
        if (glog[k] != exp_g[k]) begin
          n_errors++; $display("FAIL %s grant[%0d]: got %0d want %0d", name, k, glog[k], exp_g[k]);
        end
      end
    end
    glog.delete();
  endtask

  task automatic check_data(input string name);
    int obs[$];
    for (int i = 0; i < N; i++) begin
      obs.delete();
      foreach (dlog[k]) if (dlog[k] / 256 == i) obs.push_back(dlog[k] % 256);
      n_checks++;
      if (obs.size() != exp_id[i].size()) begin
        n_errors++; $display("FAIL %s beats_req%0d: got %0d want %0d", name, i, obs.size(), exp_id[i].size());
      end else begin
        foreach (obs[k]) begin
          if (obs[k] != exp_id[i][k]) begin
            n_errors++; $display("FAIL %s data_req%0d[%0d]: got %h want %h", name, i, k, obs[k], exp_id[i][k]);
          end
        end
      end
      exp_id[i].delete();
    end
    dlog.delete();
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy, fifo_we, req_ready, grant_id, fifo_d} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got busy=%0b we=%0b ready=%b gid=%0d d=%h want all 0",
               busy, fifo_we, req_ready, grant_id, fifo_d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_round_robin();
    int cyc;
    for (int i = 0; i < N; i++) push_pkt(i, 3);
    run_until_drained(200, cyc);
    n_checks++;
    if (cyc != 16) begin
      n_errors++; $display("FAIL rr_cycles: got %0d want 16", cyc);
    end
    n_checks++;
    if (dlog.size() != 12) begin
      n_errors++; $display("FAIL rr_writes: got %0d want 12", dlog.size());
    end
    check_grants("rr", '{0, 1, 2, 3});
    check_data("rr");
  endtask

  task automatic test_valid_drop();
    int cyc;
    push_pkt(0, 6);
    push_pkt(3, 2);
    wait_writes(2);
    hold[0] = 3;
    stall_cycles = 0;
    run_until_drained(200, cyc);
    n_checks++;
    if (stall_cycles != 3) begin
      n_errors++; $display("FAIL drop_stall: got %0d want 3", stall_cycles);
    end
    check_grants("drop", '{0, 3});
    check_data("drop");
  endtask

  task automatic test_fifo_full();
    int cyc;
    push_pkt(1, 6);
    wait_writes(2);
    full_cycles = 5;
    stall_cycles = 0;
    run_until_drained(200, cyc);
    n_checks++;
    if (stall_cycles != 5) begin
      n_errors++; $display("FAIL full_stall: got %0d want 5", stall_cycles);
    end
    check_grants("full", '{1});
    check_data("full");
  endtask

  task automatic test_max_burst();
    int cyc;
    push_pkt(2, 20);
    run_until_drained(200, cyc);
    n_checks++;
    if (cyc != 23) begin
      n_errors++; $display("FAIL burst_cycles: got %0d want 23", cyc);
    end
    check_grants("burst", '{2, 2, 2});
    check_data("burst");
  endtask

  task automatic test_random();
    int cyc;
    rand_gaps = 1; rand_full = 1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_pkt(i, int'($urandom_range(1, 12)));
    run_until_drained(3000, cyc);
    rand_gaps = 0; rand_full = 0;
    glog.delete();
    check_data("random");
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    push_pkt(2, 5);
    wait_writes(1);
    drive_inputs();
    #1;
    n_checks++;
    if (fifo_we !== 1'b1) begin
      n_errors++; $display("FAIL beat2_presented: got we=%0b want 1", fifo_we);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, fifo_we, req_ready, grant_id, fifo_d} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got busy=%0b we=%0b ready=%b gid=%0d d=%h want all 0",
               busy, fifo_we, req_ready, grant_id, fifo_d);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_pkt(3, 2);
    push_pkt(1, 2);
    run_until_drained(100, cyc);
    check_grants("post_reset", '{1, 3});
    check_data("post_reset");
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    int cyc;
    for (int p = 0; p < 8200; p++) push_pkt(1, 8);
    run_until_drained(80000, cyc);
    n_checks++;
    if (stats_beats[31:16] !== 16'hFFFF) begin
      n_errors++; $display("FAIL stats_sat: got %h want ffff", stats_beats[31:16]);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (stats_beats[i*16 +: 16] !== 16'(m_stats[i])) begin
        n_errors++; $display("FAIL stats_req%0d: got %0d want %0d", i, stats_beats[i*16 +: 16], m_stats[i]);
      end
    end
    glog.delete();
    check_data("stats");
  endtask
`endif

  initial begin
    n_checks = 0; n_errors = 0; stall_cycles = 0;
    rand_gaps = 0; rand_full = 0;
    test_reset();
    test_round_robin();
    test_valid_drop();
    test_fifo_full();
    test_max_burst();
    test_random();
    test_reset_mid_burst();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
